// File: rtl/parity_serial_tx_if.sv
// Handshake and line bundle for parity_serial_tx.
// master: the block that feeds bytes (parity stage side).
// slave : the transmitter itself.
interface parity_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              par_in;
    logic              ready;
    logic              busy;
    logic              ser_out;
    logic              done;

    modport master (
        output load,
        output data_in,
        output par_in,
        input  ready,
        input  busy,
        input  ser_out,
        input  done
    );

    modport slave (
        input  load,
        input  data_in,
        input  par_in,
        output ready,
        output busy,
        output ser_out,
        output done
    );
endinterface

// File: rtl/parity_serial_tx.sv
// Framed serial transmitter: start(0), data LSB-first, parity, stop(1).
// The parity bit comes from the upstream parity stage and is sent verbatim.
// Build option: define PARITY_TX_TWO_STOP_EN to hold the stop bit for two bit
// times instead of one.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, ready for load
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, one per bit time
// PARITY | captured parity bit on the line
// STOP   | stop bit (1); leaving it raises done for one cycle
module parity_serial_tx #(
    parameter int DATA_W    = 8,
    parameter int BIT_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    parity_serial_tx_if.slave  bus
);

`ifdef PARITY_TX_TWO_STOP_EN
    localparam int STOP_TICKS = 2 * BIT_TICKS;
`else
    localparam int STOP_TICKS = BIT_TICKS;
`endif
    localparam int TICK_W = $clog2(STOP_TICKS + 1);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_nxt;
    logic              par_q, par_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              stop_end;

    assign bit_end   = (tick_q == TICK_W'(BIT_TICKS - 1));
    assign stop_end  = (tick_q == TICK_W'(STOP_TICKS - 1));
    assign shift_nxt = shift_q >> 1;

    // Register all state; reset returns the line to idle and drops any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; ser_d is the value the line will show during the
    // next bit, so the registered output changes exactly on bit boundaries.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        ser_d   = ser_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                if (bus.load) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = bus.data_in;
                    par_d   = bus.par_in;
                    ser_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tick_d  = '0;
                    ser_d   = shift_q[0];
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_d = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                        ser_d   = par_q;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_nxt;
                        ser_d   = shift_nxt[0];
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tick_d  = '0;
                    ser_d   = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    ser_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                ser_d   = 1'b1;
            end
        endcase
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.ser_out = ser_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx with a per-cycle expectation queue.
// Build option PARITY_TX_TWO_STOP_EN is honoured by the frame model.
module tb_parity_serial_tx;

    localparam int DW = 8;
    localparam int BT = 4;
`ifdef PARITY_TX_TWO_STOP_EN
    localparam int STOP_T = 2 * BT;
`else
    localparam int STOP_T = BT;
`endif
    localparam int F = (DW + 2) * BT + STOP_T;

    typedef struct packed {
        logic ser;
        logic done;
        logic ready;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n;
    exp_t q[$];

    parity_serial_tx_if #(.DATA_W(DW)) bus ();

    parity_serial_tx #(.DATA_W(DW), .BIT_TICKS(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_bit(input logic b, input int cnt);
        exp_t e;
        e.ser   = b;
        e.done  = 1'b0;
        e.ready = 1'b0;
        for (int i = 0; i < cnt; i++) q.push_back(e);
    endtask

    // Expected line for one frame, plus the done/ready cycle that follows it.
    task automatic push_frame(input logic [DW-1:0] d, input logic p);
        exp_t e;
        push_bit(1'b0, BT);
        for (int i = 0; i < DW; i++) push_bit(d[i], BT);
        push_bit(p, BT);
        push_bit(1'b1, STOP_T);
        e.ser   = 1'b1;
        e.done  = 1'b1;
        e.ready = 1'b1;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp_v);
        end
    endtask

    // One clock; observe outputs 1 time unit after the edge against the queue
    // front, or against idle when nothing is outstanding.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
        end else begin
            e.ser   = 1'b1;
            e.done  = 1'b0;
            e.ready = 1'b1;
        end
        chk("ser_out", bus.ser_out, e.ser);
        chk("done", bus.done, e.done);
        chk("ready", bus.ready, e.ready);
        chk("busy", bus.busy, ~e.ready);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic p);
        bus.load    = 1'b1;
        bus.data_in = d;
        bus.par_in  = p;
        push_frame(d, p);
        step();
        bus.load = 1'b0;
    endtask

    // Run until done, bounded; the cycle count since accept must be F+1.
    task automatic wait_done(input string tag);
        n = 1;
        while (bus.done !== 1'b1 && n < 4 * F) begin
            step();
            n++;
        end
        checks++;
        assert (n == F + 1) else begin
            errors++;
            $error("FAIL %s done_latency observed=%0d expected=%0d", tag, n, F + 1);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 8'h5A;
        bus.par_in  = 1'b1;

        // Reset held two cycles with load high: reset must win.
        step();
        step();
        rst      = 1'b0;
        bus.load = 1'b0;
        repeat (3) step();

        // Basic frame 8'hA5, parity 0.
        send(8'hA5, 1'b0);
        wait_done("frame_a5");
        repeat (4) step();

        // Load during a frame is ignored and does not corrupt captured data.
        send(8'h00, 1'b0);
        repeat (10) step();
        bus.load    = 1'b1;
        bus.data_in = 8'hFF;
        bus.par_in  = 1'b1;
        repeat (5) step();
        bus.load = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 4 * F) begin
            step();
            n++;
        end
        repeat (8) step();

        // Back-to-back: second load presented in the done cycle.
        send(8'h3C, 1'b0);
        repeat (F) step();
        bus.load    = 1'b1;
        bus.data_in = 8'hC3;
        bus.par_in  = 1'b0;
        push_frame(8'hC3, 1'b0);
        step();
        bus.load = 1'b0;
        wait_done("b2b_c3");
        repeat (4) step();

        // Reset at cycle 20 of a frame: abandon it, no done, then a clean frame.
        send(8'h5A, 1'b1);
        repeat (19) step();
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        repeat (10) step();
        send(8'hA5, 1'b1);
        wait_done("after_rst");
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
